// File: rtl/merge_arbiter32.sv
// Round-robin arbiter that merges 32 pulse-driven requesters onto one
// downstream channel, using a one-hot grant and a per-requester free pulse.
module merge_arbiter32 #(
  parameter int N_REQ = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_drive,
  input  logic             i_freeNext,
  output logic             o_driveNext,
  output logic [N_REQ-1:0] o_data,
  output logic [IDX_W-1:0] o_grantIdx,
  output logic [N_REQ-1:0] o_free,
  output logic             o_busy,
  output logic [IDX_W:0]   o_pendCnt,
  output logic             o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_pending;
  logic [IDX_W-1:0] r_ptr;
  logic             r_driveNext;
  logic [N_REQ-1:0] r_data;
  logic [IDX_W-1:0] r_grantIdx;
  logic [N_REQ-1:0] r_free;
  logic             r_busy;
  logic [IDX_W:0]   r_pendCnt;
  logic             r_err;

  logic [IDX_W-1:0] w_selIdx;
  logic             w_selFound;
  logic [IDX_W-1:0] w_probe;
  logic             w_complete;
  logic [N_REQ-1:0] w_clearMask;
  logic [N_REQ-1:0] w_pendingNext;
  logic [IDX_W:0]   w_pendCntNext;
  logic             w_dupDrive;
  logic             w_badFree;
  logic [N_REQ-1:0] w_selOneHot;

  // First pending index at or above the pointer, wrapping 31 -> 0.
  always_comb begin
    w_selIdx   = '0;
    w_selFound = 1'b0;
    w_probe    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_probe = r_ptr + IDX_W'(k);
      if (!w_selFound && r_pending[w_probe]) begin
        w_selIdx   = w_probe;
        w_selFound = 1'b1;
      end
    end
  end

  assign w_selOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << w_selIdx;
  assign w_complete  = (r_state == S_WAIT) && i_freeNext;
  assign w_clearMask = w_complete ? r_data : '0;

  // A drive on an already-pending index is dropped; pending is judged pre-edge.
  assign w_pendingNext = (r_pending & ~w_clearMask) | (i_drive & ~r_pending);
  assign w_dupDrive    = |(i_drive & r_pending);
  assign w_badFree     = i_freeNext && (r_state != S_WAIT);

  always_comb begin
    w_pendCntNext = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pendCntNext = w_pendCntNext + (IDX_W+1)'(w_pendingNext[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_driveNext <= 1'b0;
      r_data      <= '0;
      r_grantIdx  <= '0;
      r_free      <= '0;
      r_busy      <= 1'b0;
      r_pendCnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pending   <= w_pendingNext;
      r_pendCnt   <= w_pendCntNext;
      r_driveNext <= 1'b0;
      r_free      <= '0;
      if (w_dupDrive || w_badFree) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_data      <= w_selOneHot;
            r_grantIdx  <= w_selIdx;
            r_driveNext <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_freeNext) begin
            r_free     <= r_data;
            r_data     <= '0;
            r_grantIdx <= '0;
            r_ptr      <= r_grantIdx + IDX_W'(1);
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_driveNext = r_driveNext;
  assign o_data      = r_data;
  assign o_grantIdx  = r_grantIdx;
  assign o_free      = r_free;
  assign o_busy      = r_busy;
  assign o_pendCnt   = r_pendCnt;
  assign o_err       = r_err;

endmodule

// File: tb/tb_merge_arbiter32.sv
// Scoreboard bench for merge_arbiter32: expected grant indices are queued
// as requests are driven and checked as each o_driveNext appears.
module tb_merge_arbiter32;

  logic        clk;
  logic        rst;
  logic [31:0] i_drive;
  logic        i_freeNext;
  logic        o_driveNext;
  logic [31:0] o_data;
  logic [4:0]  o_grantIdx;
  logic [31:0] o_free;
  logic        o_busy;
  logic [5:0]  o_pendCnt;
  logic        o_err;

  int totalCount = 0;
  int badCount   = 0;
  int maxPend    = 0;
  int driveCount = 0;
  int expQ[$];

  merge_arbiter32 dut (
    .clk         (clk),
    .rst         (rst),
    .i_drive     (i_drive),
    .i_freeNext  (i_freeNext),
    .o_driveNext (o_driveNext),
    .o_data      (o_data),
    .o_grantIdx  (o_grantIdx),
    .o_free      (o_free),
    .o_busy      (o_busy),
    .o_pendCnt   (o_pendCnt),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (int'(o_pendCnt) > maxPend) maxPend = int'(o_pendCnt);
    if (o_driveNext) driveCount++;
  endtask

  task automatic applyStimulus(input logic [31:0] drive, input logic freeNext);
    i_drive    = drive;
    i_freeNext = freeNext;
    tick();
    i_drive    = '0;
    i_freeNext = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
  endtask

  // Wait for the next grant, check it against the scoreboard, hold it for
  // holdCycles WAIT cycles, complete it, then spend one edge applying redrive.
  task automatic serviceOne(input logic [31:0] redrive, input int expPend, input int holdCycles);
    int waited = 0;
    int exp;
    logic [31:0] expHot;
    while (!o_driveNext && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("driveNextSeen", {31'd0, o_driveNext}, 32'd1);
    exp    = (expQ.size() > 0) ? expQ.pop_front() : 32;
    expHot = (exp < 32) ? (32'd1 << exp) : 32'd0;
    checkOutput("grantIdx", {27'd0, o_grantIdx}, exp);
    checkOutput("grantData", o_data, expHot);
    checkOutput("busyOnGrant", {31'd0, o_busy}, 32'd1);
    applyStimulus('0, 1'b0);
    checkOutput("driveNextOnePulse", {31'd0, o_driveNext}, 32'd0);
    checkOutput("dataIssueHold", o_data, expHot);
    for (int h = 0; h < holdCycles; h++) begin
      applyStimulus('0, 1'b0);
      checkOutput("dataWaitHold", o_data, expHot);
    end
    applyStimulus('0, 1'b1);
    checkOutput("freePulse", o_free, expHot);
    checkOutput("dataAfterFree", o_data, 32'd0);
    checkOutput("busyAfterFree", {31'd0, o_busy}, 32'd0);
    if (expPend >= 0) checkOutput("pendCntAfterFree", {26'd0, o_pendCnt}, expPend);
    applyStimulus(redrive, 1'b0);
    checkOutput("freeClears", o_free, 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_data"}, o_data, 32'd0);
    checkOutput({tag, "_idx"}, {27'd0, o_grantIdx}, 32'd0);
    checkOutput({tag, "_free"}, o_free, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    checkOutput({tag, "_drvNext"}, {31'd0, o_driveNext}, 32'd0);
    checkOutput({tag, "_pendCnt"}, {26'd0, o_pendCnt}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    i_drive    = '0;
    i_freeNext = 1'b0;
    tick();
    tick();
    doReset();
    checkIdleOutputs("reset");
    checkOutput("resetErr", {31'd0, o_err}, 32'd0);

    // Single request on bit 4, completed at edge 4.
    applyStimulus(32'h0000_0010, 1'b0);
    checkOutput("singlePendCnt", {26'd0, o_pendCnt}, 32'd1);
    checkOutput("singleNoGrantYet", o_data, 32'd0);
    expQ.push_back(4);
    serviceOne('0, 0, 1);
    checkOutput("singleErr", {31'd0, o_err}, 32'd0);

    // Round robin over 0, 5, 31, then wrap back to 0 before 3.
    doReset();
    expQ.push_back(0);
    expQ.push_back(5);
    expQ.push_back(31);
    applyStimulus(32'h8000_0021, 1'b0);
    checkOutput("rrPendCnt", {26'd0, o_pendCnt}, 32'd3);
    serviceOne('0, 2, 0);
    serviceOne('0, 1, 0);
    serviceOne('0, 0, 0);
    expQ.push_back(0);
    expQ.push_back(3);
    applyStimulus(32'h0000_0009, 1'b0);
    serviceOne('0, 1, 0);
    serviceOne('0, 0, 0);

    // Fairness: bits 0 and 1 re-request while bit 2 waits.
    doReset();
    maxPend = 0;
    expQ.push_back(0);
    expQ.push_back(1);
    expQ.push_back(2);
    expQ.push_back(0);
    expQ.push_back(1);
    applyStimulus(32'h0000_0007, 1'b0);
    serviceOne(32'h0000_0001, -1, 0);
    serviceOne(32'h0000_0002, -1, 0);
    serviceOne('0, 2, 0);
    serviceOne('0, 1, 0);
    serviceOne('0, 0, 0);
    checkOutput("fairMaxPend", maxPend, 32'd3);

    // Protocol errors.
    doReset();
    applyStimulus('0, 1'b1);
    checkOutput("idleFreeErr", {31'd0, o_err}, 32'd1);
    checkIdleOutputs("idleFree");
    doReset();
    checkOutput("errClearedByReset", {31'd0, o_err}, 32'd0);
    applyStimulus(32'h0000_0080, 1'b0);
    checkOutput("firstDrive7Err", {31'd0, o_err}, 32'd0);
    checkOutput("firstDrive7Cnt", {26'd0, o_pendCnt}, 32'd1);
    expQ.push_back(7);
    applyStimulus(32'h0000_0080, 1'b0);
    checkOutput("dupDrive7Err", {31'd0, o_err}, 32'd1);
    checkOutput("dupDrive7Cnt", {26'd0, o_pendCnt}, 32'd1);
    serviceOne('0, 0, 0);
    checkOutput("errSticky", {31'd0, o_err}, 32'd1);

    // Reset in WAIT with four requests pending.
    doReset();
    applyStimulus(32'h0000_001E, 1'b0);
    checkOutput("midPendCnt", {26'd0, o_pendCnt}, 32'd4);
    applyStimulus('0, 1'b0);
    checkOutput("midGrantIdx", {27'd0, o_grantIdx}, 32'd1);
    applyStimulus('0, 1'b0);
    checkOutput("midInWait", {31'd0, o_busy}, 32'd1);
    rst        = 1'b1;
    i_freeNext = 1'b1;
    i_drive    = 32'h0000_0200;
    tick();
    rst        = 1'b0;
    i_freeNext = 1'b0;
    i_drive    = '0;
    checkIdleOutputs("midReset");
    checkOutput("midResetErr", {31'd0, o_err}, 32'd0);
    tick();
    checkIdleOutputs("postReset");
    applyStimulus('0, 1'b1);
    checkOutput("postResetFreeErr", {31'd0, o_err}, 32'd1);

    // All 32 requesters at once: index order, pendCnt counts down.
    doReset();
    for (int i = 0; i < 32; i++) expQ.push_back(i);
    applyStimulus(32'hFFFF_FFFF, 1'b0);
    checkOutput("allPendCnt", {26'd0, o_pendCnt}, 32'd32);
    driveCount = 0;
    for (int i = 0; i < 32; i++) serviceOne('0, 31 - i, 0);
    checkOutput("allDriveNextCount", driveCount, 32'd32);
    checkOutput("allErr", {31'd0, o_err}, 32'd0);

    checkOutput("sbDrained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/merge_arbiter32.md
# merge_arbiter32

Synchronous round-robin arbiter that shares one downstream merged channel of the cache-replacement control path among 32 requesters. Requesters post single-cycle drive pulses, which the block latches as pending. The block grants one pending requester at a time with a one-hot grant vector. It holds that grant until the downstream channel signals completion, then returns a per-requester free pulse. It is the clocked counterpart of the 32-way mutex merge and presents the same drive/free/one-hot-data contract on both sides.

## Interface
Parameters:
- N_REQ, 32, number of requesters; the block is only defined for 32.
- IDX_W, 5, width of the grant index (log2 N_REQ).

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_drive  in  32  per-requester request pulse; one cycle high = one request.
- i_freeNext  in  1  downstream completion pulse for the current grant.
- o_driveNext  out  1  one-cycle pulse to downstream when a new grant is issued.
- o_data  out  32  one-hot grant vector; all zeros when no grant is held.
- o_grantIdx  out  5  binary index of the granted requester; 0 when idle.
- o_free  out  32  one-cycle pulse to the requester whose grant completed.
- o_busy  out  1  high while a grant is held (states ISSUE and WAIT).
- o_pendCnt  out  6  popcount of pending requests, range 0..32.
- o_err  out  1  sticky protocol-error flag; cleared only by rst.

## Operation
- pending[31:0] register:
  - i_drive[i] sampled high while pending[i]=0 sets pending[i].
  - i_drive[i] while pending[i]=1 is dropped and sets o_err. This includes the edge on which requester i's grant completes, because pending is evaluated pre-edge.
- Round-robin pointer ptr[4:0]:
  - Selection picks the first pending index at or above ptr, wrapping 31->0.
  - On completion of grant g, ptr becomes (g+1) mod 32, so 31 wraps to 0.
- FSM states:
  - IDLE: o_data=0, o_busy=0. If pending != 0, register the selected g: o_data=onehot(g), o_grantIdx=g, o_driveNext=1, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly one cycle): o_driveNext=1, go to WAIT unconditionally.
  - WAIT: hold o_data and o_grantIdx. On i_freeNext:
    - o_free[g]=1 for the next cycle;
    - pending[g]=0;
    - o_data=0 and o_grantIdx=0;
    - ptr=g+1;
    - go to IDLE.
- i_freeNext sampled in IDLE or ISSUE is ignored and sets o_err.
- A pending request on a non-granted index survives any number of grants; round robin bounds its wait to 31 grants.
- o_pendCnt is registered; it reflects pending after each edge.
- Reset (synchronous, takes effect mid-operation):
  - pending=0, ptr=0, state=IDLE, o_err=0, all outputs 0.
  - Any outstanding grant is dropped silently; no o_free is issued for it.
  - i_drive and i_freeNext sampled on the reset edge are discarded.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Request to grant: i_drive[i] sampled at edge k, pending set after k. With the block in IDLE at k+1, o_data and o_driveNext are high after edge k+1. Minimum latency is 2 cycles.
- o_driveNext is high for exactly one cycle per grant, coincident with the first cycle of o_data.
- Completion: i_freeNext sampled in WAIT at edge m gives, after m, o_free[g]=1 for one cycle, o_data=0 and o_busy=0. The earliest next grant appears after edge m+1.
- Maximum throughput is one grant per 3 cycles (IDLE, ISSUE, WAIT with immediate free).
- The value of o_data is stable for the entire ISSUE+WAIT interval.

## Test plan
- Single request: pulse i_drive=32'h0000_0010 at edge 0, then i_freeNext at edge 4.
  - After edge 1: o_data=32'h10, o_grantIdx=4, o_driveNext=1.
  - After edge 2: o_driveNext=0.
  - After edge 4: o_free=32'h10 for one cycle, o_data=0, o_pendCnt=0.
- Round robin: drive bits 0, 5 and 31 on the same edge and complete each grant immediately.
  - Grant order is 0, 5, 31; after 31 completes, ptr=0.
  - A new drive on bits 3 and 0 then grants 0 before 3.
- Fairness under load: keep bits 0 and 1 re-requesting after every free while bit 2 is pending.
  - Bit 2 is granted within 3 grants.
  - o_pendCnt never exceeds 3.
- Protocol errors:
  - i_freeNext in IDLE sets o_err=1 with no other state change.
  - A second i_drive[7] while pending[7]=1 sets o_err and o_pendCnt stays unchanged.
  - o_err holds until rst.
- Reset mid-grant: assert rst for one edge in WAIT with 4 requests pending.
  - All outputs become 0 and o_pendCnt=0.
  - No o_free pulse is issued.
  - i_freeNext after reset sets o_err.
- All 32 bits driven at once: 32 consecutive grants occur in index order 0..31, with one o_driveNext per grant and o_pendCnt counting down 32->0.
